// File: rtl/i2c_reg_seq.sv
// I2C register-access sequencer: turns one host read/write request into a series of
// byte-level commands for an I2C engine, with a per-command watchdog and STOP-on-abort.
module i2c_reg_seq #(
  parameter logic [6:0]  DEV_ADDR       = 7'h36,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        rw,
  input  logic [7:0]  reg_addr,
  input  logic        nbytes,
  input  logic [15:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] rd_data,
  output logic [1:0]  instruction,
  output logic        enable,
  output logic [7:0]  byte_to_send,
  output logic        send_nack,
  input  logic        complete,
  input  logic [7:0]  byte_received
);

  localparam int unsigned WdW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] CmdStart = 2'd0;
  localparam logic [1:0] CmdStop  = 2'd1;
  localparam logic [1:0] CmdRead  = 2'd2;
  localparam logic [1:0] CmdWrite = 2'd3;

  typedef enum logic [3:0] {
    StIdle, StStart, StDevW, StReg, StWdH, StWdL, StRstart,
    StDevR, StRd0, StRd1, StNack, StStop, StAbort, StDone
  } state_e;

  // Gap is the idle cycle before each issue; it gives the engine time to return to idle.
  typedef enum logic [1:0] {PhGap, PhIssue, PhWait} phase_e;

  state_e         state_q;
  state_e         state_next;
  phase_e         phase_q;
  logic [WdW-1:0] wdog_q;
  logic           rw_q;
  logic           nbytes_q;
  logic [7:0]     reg_addr_q;
  logic [15:0]    wr_data_q;
  logic [1:0]     cmd_instr;
  logic [7:0]     cmd_byte;
  logic           cmd_nack;

  // Command issued by the current state and the state that follows it on success.
  always_comb begin
    cmd_instr  = CmdWrite;
    cmd_byte   = 8'h00;
    cmd_nack   = 1'b0;
    state_next = StDone;
    case (state_q)
      StStart: begin
        cmd_instr  = CmdStart;
        state_next = StDevW;
      end
      StDevW: begin
        cmd_byte   = {DEV_ADDR, 1'b0};
        state_next = StReg;
      end
      StReg: begin
        cmd_byte = reg_addr_q;
        if (rw_q)          state_next = StRstart;
        else if (nbytes_q) state_next = StWdH;
        else               state_next = StWdL;
      end
      StWdH: begin
        cmd_byte   = wr_data_q[15:8];
        state_next = StWdL;
      end
      StWdL: begin
        cmd_byte   = wr_data_q[7:0];
        state_next = StStop;
      end
      StRstart: begin
        cmd_instr  = CmdStart;
        state_next = StDevR;
      end
      StDevR: begin
        cmd_byte   = {DEV_ADDR, 1'b1};
        state_next = StRd0;
      end
      StRd0: begin
        cmd_instr  = CmdRead;
        state_next = nbytes_q ? StRd1 : StNack;
      end
      StRd1: begin
        cmd_instr  = CmdRead;
        state_next = StNack;
      end
      StNack: begin
        cmd_instr  = CmdRead;
        cmd_nack   = 1'b1;
        state_next = StStop;
      end
      StStop, StAbort: begin
        cmd_instr  = CmdStop;
        state_next = StDone;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      phase_q      <= PhGap;
      wdog_q       <= '0;
      rw_q         <= 1'b0;
      nbytes_q     <= 1'b0;
      reg_addr_q   <= 8'h00;
      wr_data_q    <= 16'h0000;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      rd_data      <= 16'h0000;
      instruction  <= CmdStart;
      enable       <= 1'b0;
      byte_to_send <= 8'h00;
      send_nack    <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            rw_q       <= rw;
            nbytes_q   <= nbytes;
            reg_addr_q <= reg_addr;
            wr_data_q  <= wr_data;
            busy       <= 1'b1;
            state_q    <= StStart;
            phase_q    <= PhGap;
          end
        end
        StDone: begin
          done    <= 1'b0;
          error   <= 1'b0;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          case (phase_q)
            PhGap: begin
              enable       <= 1'b1;
              instruction  <= cmd_instr;
              byte_to_send <= cmd_byte;
              send_nack    <= cmd_nack;
              wdog_q       <= '0;
              phase_q      <= PhIssue;
            end
            PhIssue: begin
              enable  <= 1'b0;
              phase_q <= PhWait;
            end
            default: begin
              // complete wins over an expiring watchdog in the same cycle
              if (complete) begin
                send_nack <= 1'b0;
                phase_q   <= PhGap;
                state_q   <= state_next;
                if (state_q == StRd0) rd_data <= {8'h00, byte_received};
                if (state_q == StRd1) rd_data <= {rd_data[7:0], byte_received};
                if (state_next == StDone) begin
                  done  <= 1'b1;
                  error <= (state_q == StAbort);
                end
              end else if (wdog_q == WdLast) begin
                send_nack <= 1'b0;
                phase_q   <= PhGap;
                if (state_q == StAbort) begin
                  state_q <= StDone;
                  done    <= 1'b1;
                  error   <= 1'b1;
                end else begin
                  state_q <= StAbort;
                end
              end else begin
                wdog_q <= wdog_q + WdW'(1);
              end
            end
          endcase
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_reg_seq.sv
// Self-checking bench for i2c_reg_seq: an engine model pops expected commands from a
// scoreboard as they are issued, and transaction results are popped when done pulses.
module tb_i2c_reg_seq;

  localparam logic [6:0]  DevAddr = 7'h36;
  localparam int unsigned Timeout = 4096;
  localparam logic [1:0]  CmdStart = 2'd0;
  localparam logic [1:0]  CmdStop  = 2'd1;
  localparam logic [1:0]  CmdRead  = 2'd2;
  localparam logic [1:0]  CmdWrite = 2'd3;

  typedef struct packed {
    logic [1:0] instr;
    logic [7:0] byt;
    logic       nack;
  } cmd_t;

  typedef struct packed {
    logic        err;
    logic [15:0] rd;
  } res_t;

  logic        clk = 1'b0;
  logic        reset, start, rw, nbytes, complete;
  logic [7:0]  reg_addr, byte_received, byte_to_send;
  logic [15:0] wr_data, rd_data;
  logic        busy, done, error, enable, send_nack;
  logic [1:0]  instruction;

  i2c_reg_seq #(.DEV_ADDR(DevAddr), .TIMEOUT_CYCLES(Timeout)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .rw            (rw),
    .reg_addr      (reg_addr),
    .nbytes        (nbytes),
    .wr_data       (wr_data),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .rd_data       (rd_data),
    .instruction   (instruction),
    .enable        (enable),
    .byte_to_send  (byte_to_send),
    .send_nack     (send_nack),
    .complete      (complete),
    .byte_received (byte_received)
  );

  always #5 clk = ~clk;

  cmd_t        exp_cmds[$];
  res_t        exp_res[$];
  logic [7:0]  rd_bytes[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int          cyc = 0, last_cpl = -100, lat_cnt = 0, stall_cyc = 0;
  int          fixed_lat = -1, cmd_total = 0, withhold_at = -1;
  int          flush_cnt = 0, seen_flush = 0;
  bit          pending = 1'b0, stalled = 1'b0, hold_ok = 1'b1, prev_en = 1'b0;
  bit          inject_cpl = 1'b0;
  cmd_t        cur;
  logic [15:0] model_rd = 16'h0000;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic cmd_t mk(input logic [1:0] instr, input logic [7:0] byt, input logic nack);
    cmd_t c;
    c.instr = instr;
    c.byt   = byt;
    c.nack  = nack;
    return c;
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_error"}, error, 1'b0);
    check({tag, "_enable"}, enable, 1'b0);
    check({tag, "_send_nack"}, send_nack, 1'b0);
    check({tag, "_instruction"}, instruction, 2'd0);
    check({tag, "_byte_to_send"}, byte_to_send, 8'h00);
    check({tag, "_rd_data"}, rd_data, 16'h0000);
  endtask

  // Expected command list and result; withhold >= 0 makes the engine stall on that command.
  task automatic push_expected(input logic rw_v, input logic [7:0] ra, input logic nb,
                               input logic [15:0] wd, input logic [7:0] b0,
                               input logic [7:0] b1, input int withhold);
    cmd_t seq[$];
    res_t r;
    seq.push_back(mk(CmdStart, 8'h00, 1'b0));
    seq.push_back(mk(CmdWrite, {DevAddr, 1'b0}, 1'b0));
    seq.push_back(mk(CmdWrite, ra, 1'b0));
    if (!rw_v) begin
      if (nb) seq.push_back(mk(CmdWrite, wd[15:8], 1'b0));
      seq.push_back(mk(CmdWrite, wd[7:0], 1'b0));
    end else begin
      seq.push_back(mk(CmdStart, 8'h00, 1'b0));
      seq.push_back(mk(CmdWrite, {DevAddr, 1'b1}, 1'b0));
      seq.push_back(mk(CmdRead, 8'h00, 1'b0));
      if (nb) seq.push_back(mk(CmdRead, 8'h00, 1'b0));
      seq.push_back(mk(CmdRead, 8'h00, 1'b1));
      rd_bytes.push_back(b0);
      if (nb) rd_bytes.push_back(b1);
    end
    seq.push_back(mk(CmdStop, 8'h00, 1'b0));
    if (withhold >= 0) begin
      while (int'(seq.size()) > withhold + 1) void'(seq.pop_back());
      seq.push_back(mk(CmdStop, 8'h00, 1'b0));
      withhold_at = cmd_total + withhold;
    end else begin
      withhold_at = -1;
      if (rw_v) model_rd = nb ? {b0, b1} : {8'h00, b0};
    end
    foreach (seq[i]) exp_cmds.push_back(seq[i]);
    r.err = (withhold >= 0);
    r.rd  = model_rd;
    exp_res.push_back(r);
  endtask

  task automatic drive_start(input logic rw_v, input logic [7:0] ra, input logic nb,
                             input logic [15:0] wd);
    @(posedge clk);
    #1;
    rw = rw_v; reg_addr = ra; nbytes = nb; wr_data = wd; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_after_start", busy, 1'b1);
  endtask

  task automatic run_txn(input logic rw_v, input logic [7:0] ra, input logic nb,
                         input logic [15:0] wd, input logic [7:0] b0, input logic [7:0] b1,
                         input int withhold, input bit glitch);
    res_t r;
    bit   got_done = 1'b0;
    push_expected(rw_v, ra, nb, wd, b0, b1, withhold);
    drive_start(rw_v, ra, nb, wd);
    for (int c = 0; c < int'(Timeout) * 2 + 500; c++) begin
      // a start pulse with different inputs mid-transaction must be ignored
      if (glitch && c == 3) begin
        start = 1'b1; rw = ~rw_v; reg_addr = 8'hFF; nbytes = ~nb;
      end
      if (c == 4) start = 1'b0;
      @(posedge clk);
      #1;
      if (done) begin
        got_done = 1'b1;
        break;
      end
    end
    start = 1'b0;
    check("done_seen", got_done, 1'b1);
    if (got_done && exp_res.size() != 0) begin
      r = exp_res.pop_front();
      check("error", error, r.err);
      check("rd_data", rd_data, r.rd);
      check("busy_in_done", busy, 1'b1);
      @(posedge clk);
      #1;
      check("busy_after_done", busy, 1'b0);
      check("done_one_cycle", done, 1'b0);
      check("cmds_consumed", exp_cmds.size(), 0);
    end
  endtask

  task automatic reset_mid_read();
    bit seen = 1'b0;
    fixed_lat = 6;
    push_expected(1'b1, 8'h0E, 1'b1, 16'h0000, 8'h11, 8'h22, -1);
    drive_start(1'b1, 8'h0E, 1'b1, 16'h0000);
    for (int c = 0; c < 300; c++) begin
      @(posedge clk);
      #1;
      if (enable && instruction == CmdRead && !send_nack) begin
        seen = 1'b1;
        break;
      end
    end
    check("rd0_reached", seen, 1'b1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    flush_cnt++;
    exp_res.delete();
    model_rd = 16'h0000;
    @(posedge clk);
    #1;
    check_reset_vals("reset_mid_rd0");
    reset = 1'b0;
    fixed_lat = -1;
    repeat (12) @(posedge clk);
    #1;
    check("idle_after_mid_reset", busy, 1'b0);
  endtask

  // Engine model: the only driver of complete/byte_received.
  initial begin : engine
    cmd_t want;
    complete = 1'b0;
    byte_received = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      complete = 1'b0;
      byte_received = 8'($urandom);
      if (flush_cnt != seen_flush) begin
        seen_flush = flush_cnt;
        pending = 1'b0;
        stalled = 1'b0;
        exp_cmds.delete();
        rd_bytes.delete();
        last_cpl = cyc - 100;
      end
      if (inject_cpl) begin
        complete = 1'b1;
        byte_received = 8'h99;
      end
      if (pending) begin
        hold_ok = hold_ok && (instruction == cur.instr) && (byte_to_send == cur.byt) &&
                  (send_nack == cur.nack);
        if (lat_cnt == 0) begin
          complete = 1'b1;
          if (cur.instr == CmdRead && !cur.nack && rd_bytes.size() != 0)
            byte_received = rd_bytes.pop_front();
          pending = 1'b0;
          last_cpl = cyc;
          check("cmd_hold_during_wait", hold_ok, 1'b1);
        end else begin
          lat_cnt--;
        end
      end
      if (enable) begin
        check("enable_one_cycle", prev_en, 1'b0);
        check("issue_gap_ge2", (cyc - last_cpl) >= 2, 1'b1);
        check("issue_not_in_wait", pending, 1'b0);
        if (stalled) begin
          check("timeout_span", (cyc - stall_cyc >= int'(Timeout)) &&
                (cyc - stall_cyc <= int'(Timeout) + 4), 1'b1);
          stalled = 1'b0;
        end
        check("cmd_expected", exp_cmds.size() != 0, 1'b1);
        if (exp_cmds.size() != 0) begin
          want = exp_cmds.pop_front();
          check("cmd_instr", instruction, want.instr);
          check("cmd_nack", send_nack, want.nack);
          if (want.instr == CmdWrite) check("cmd_byte", byte_to_send, want.byt);
        end
        cur.instr = instruction;
        cur.byt   = byte_to_send;
        cur.nack  = send_nack;
        hold_ok   = 1'b1;
        if (cmd_total == withhold_at) begin
          stalled   = 1'b1;
          stall_cyc = cyc;
        end else begin
          pending = 1'b1;
          lat_cnt = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(3, 0));
        end
        cmd_total++;
      end
      prev_en = enable;
    end
  end

  initial begin : main
    reset = 1'b1; start = 1'b1; rw = 1'b0; reg_addr = 8'h00; nbytes = 1'b0;
    wr_data = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset_with_start");
    start = 1'b0;
    reset = 1'b0;

    run_txn(1'b0, 8'h0C, 1'b1, 16'hABCD, 8'h00, 8'h00, -1, 1'b1);
    run_txn(1'b1, 8'h0E, 1'b1, 16'h0000, 8'h0F, 8'hA5, -1, 1'b0);
    run_txn(1'b0, 8'h20, 1'b0, 16'h1255, 8'h00, 8'h00, -1, 1'b0);

    // complete pulses while idle must not start anything or touch rd_data
    inject_cpl = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    inject_cpl = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("idle_cpl_busy", busy, 1'b0);
    check("idle_cpl_done", done, 1'b0);
    check("idle_cpl_rd_data", rd_data, model_rd);

    run_txn(1'b1, 8'h05, 1'b0, 16'h0000, 8'h3C, 8'h00, -1, 1'b0);
    run_txn(1'b0, 8'h0C, 1'b0, 16'h00AA, 8'h00, 8'h00, 2, 1'b0);
    run_txn(1'b0, 8'h44, 1'b1, 16'h5AA5, 8'h00, 8'h00, -1, 1'b0);
    reset_mid_read();
    run_txn(1'b1, 8'h07, 1'b0, 16'h0000, 8'h77, 8'h00, -1, 1'b0);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin : sim_limit
    #800000;
    $display("FAIL global_timeout: observed time %0t, required finish before limit", $time);
    $fatal(1, "simulation time limit");
  end

endmodule
